// File: rtl/branch_ctrl_if.sv
// Execute/fetch side bundle for branch_ctrl.
// The slave modport is the controller's view. The master modport is the view of
// whatever drives branch decisions and accepts redirects.
interface branch_ctrl_if;
  logic        BrValid;
  logic        OpReady;
  logic        Taken;
  logic [31:0] Target;
  logic [31:0] Ret;
  logic        IsLink;
  logic [4:0]  LinkReg;
  logic        FetchReady;

  logic        BrAck;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Flush;
  logic        LinkWe;
  logic [4:0]  LinkAddr;
  logic [31:0] LinkData;
  logic        AddrErr;
  logic [15:0] TakenCount;
  logic [15:0] NotTakenCount;

  modport master (
    output BrValid, OpReady, Taken, Target, Ret, IsLink, LinkReg, FetchReady,
    input  BrAck, Stall, Redirect, RedirectPC, Flush, LinkWe, LinkAddr,
           LinkData, AddrErr, TakenCount, NotTakenCount
  );

  modport slave (
    input  BrValid, OpReady, Taken, Target, Ret, IsLink, LinkReg, FetchReady,
    output BrAck, Stall, Redirect, RedirectPC, Flush, LinkWe, LinkAddr,
           LinkData, AddrErr, TakenCount, NotTakenCount
  );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: sequences execute-stage branch/jump decisions into a registered
// fetch redirect, front-end stall, wrong-path flush and link-register write.
// Optional feature macro: BRANCH_STATS_EN builds 16-bit saturating
// taken/not-taken counters; without it both count ports read 0.
module branch_ctrl (
  input  logic          Clk,
  input  logic          nRst,
  branch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, WAIT, REDIRECT} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ack;
  logic        stall;
  logic        taken_ok;
  logic        taken_bad;

  logic [31:0] target_q;
  logic [31:0] link_data_q;
  logic [4:0]  link_addr_q;
  logic        link_we_q;
  logic        addr_err_q;

  // A taken branch redirects only if its target is word aligned.
  // A misaligned taken target raises AddrErr instead.
  assign taken_ok  = bus.Taken & (bus.Target[1:0] == 2'b00);
  assign taken_bad = bus.Taken & (bus.Target[1:0] != 2'b00);

  // Next state, ack and stall. Stall drops in the cycle a waiting branch is
  // acked, so execute can advance together with the ack.
  always_comb begin
    state_nxt = state;
    ack       = 1'b0;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.BrValid) begin
          if (bus.OpReady) begin
            ack = 1'b1;
            if (taken_ok) state_nxt = REDIRECT;
          end else begin
            stall     = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!bus.BrValid) begin
          stall     = 1'b1;
          state_nxt = IDLE;
        end else if (bus.OpReady) begin
          ack       = 1'b1;
          state_nxt = taken_ok ? REDIRECT : IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      REDIRECT: begin
        // Any new BrValid is left stalled here and is acked back in IDLE.
        stall = 1'b1;
        if (bus.FetchReady) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register. An asynchronous reset drops a pending redirect at once.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Decision registers, captured on ack.
  // The link write and the AddrErr pulse last exactly the cycle after the ack.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      target_q    <= '0;
      link_data_q <= '0;
      link_addr_q <= '0;
      link_we_q   <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      link_we_q  <= ack & bus.IsLink;
      addr_err_q <= ack & taken_bad;
      if (ack) begin
        target_q    <= bus.Target;
        link_data_q <= bus.Ret;
        link_addr_q <= bus.LinkReg;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] taken_cnt;
  logic [15:0] not_taken_cnt;

  // Saturating branch statistics. A misaligned taken branch still counts as taken.
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      taken_cnt     <= '0;
      not_taken_cnt <= '0;
    end else if (ack) begin
      if (bus.Taken) taken_cnt     <= sat_inc(taken_cnt);
      else           not_taken_cnt <= sat_inc(not_taken_cnt);
    end
  end

  assign bus.TakenCount    = taken_cnt;
  assign bus.NotTakenCount = not_taken_cnt;
`else
  assign bus.TakenCount    = 16'd0;
  assign bus.NotTakenCount = 16'd0;
`endif

  assign bus.BrAck      = ack;
  assign bus.Stall      = stall;
  assign bus.Redirect   = (state == REDIRECT);
  assign bus.RedirectPC = target_q;
  // Only the fetch-stage slot is killed; the delay slot in decode survives.
  assign bus.Flush      = (state == REDIRECT) & bus.FetchReady;
  assign bus.LinkWe     = link_we_q;
  assign bus.LinkAddr   = link_addr_q;
  assign bus.LinkData   = link_data_q;
  assign bus.AddrErr    = addr_err_q;

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Sequences control-transfer instructions resolved in the execute stage. Takes branch and jump decisions from the execute-stage branch unit and issues a registered PC redirect to fetch over a ready/valid handshake. Stalls the front end while branch operands are unresolved or a redirect is pending, flushes the wrong-path fetch slot while preserving the delay slot, and schedules the link-register write for AL/JAL/JALR forms.

## Interface
- No parameters; data width fixed at 32, register index at 5.
- Clk  in  1  rising-edge clock
- nRst  in  1  asynchronous, active-low reset
- BrValid  in  1  execute stage presents a branch/jump this cycle
- OpReady  in  1  branch operands resolved (forwarding complete)
- Taken  in  1  branch unit decision
- Target  in  32  branch unit target PC
- Ret  in  32  return address (branch PC + 8)
- IsLink  in  1  instruction writes a link register
- LinkReg  in  5  link destination (31 for JAL/BxxAL, rd for JALR)
- FetchReady  in  1  fetch accepts redirect this cycle
- BrAck  out  1  branch consumed; execute may advance
- Stall  out  1  hold IF/ID/EX registers
- Redirect  out  1  redirect valid
- RedirectPC  out  32  new fetch PC
- Flush  out  1  kill instruction currently in fetch
- LinkWe  out  1  register-file write enable for link
- LinkAddr  out  5  link write index
- LinkData  out  32  link write data
- AddrErr  out  1  one-cycle pulse, misaligned taken target
- TakenCount  out  16  taken-branch counter (see Configuration)
- NotTakenCount  out  16  not-taken counter (see Configuration)

## Operation
- States: IDLE, WAIT, REDIRECT.
- IDLE, BrValid & !OpReady → WAIT. Stall=1, BrAck=0.
- IDLE or WAIT, BrValid & OpReady: BrAck=1 combinationally. Latch Target, Ret, IsLink and LinkReg into the decision registers.
  - Taken & Target[1:0]==0 → REDIRECT.
  - Taken & Target[1:0]!=0 → AddrErr pulse next cycle, no redirect, → IDLE.
  - !Taken → IDLE.
- WAIT, !BrValid (branch killed upstream) → IDLE with no side effects.
- REDIRECT: Redirect=1, RedirectPC=latched target, Stall=1.
  - On FetchReady: Flush=1 in the same cycle, → IDLE.
  - Otherwise hold all outputs stable.
- Delay slot: the instruction in decode when the branch is acked is never flushed. Only the fetch-stage instruction is flushed.
- Link: if latched IsLink, LinkWe=1 for exactly one cycle, the cycle after BrAck, with LinkAddr=LinkReg and LinkData=Ret. This applies whether taken or not; BGEZAL/BLTZAL link unconditionally.
- BrValid while in REDIRECT is ignored. Stall keeps it held, and it is acked after the return to IDLE.

## Timing
- Reset values: state IDLE. Redirect, Flush, LinkWe, AddrErr, Stall and BrAck are 0. RedirectPC, LinkData, LinkAddr and both counters are 0.
- nRst assertion mid-REDIRECT drops Redirect asynchronously. The pending redirect and link write are discarded.
- Stall is combinational from state and inputs. It is 1 in WAIT, in REDIRECT, and in IDLE when BrValid & !OpReady.
- Redirect latency: BrAck in cycle N → Redirect=1 in N+1. Minimum redirect duration is 1 cycle (FetchReady high in N+1).
- Flush = Redirect & FetchReady (combinational).
- LinkWe is registered: high in N+1 only.
- Back-to-back: a branch may be acked in the same cycle REDIRECT exits to IDLE+1. The next ack is no earlier than cycle N+2.

## Configuration
- BRANCH_STATS_EN defined: two 16-bit saturating counters.
  - TakenCount increments on each valid taken ack.
  - NotTakenCount increments on each not-taken ack.
  - Both hold at 16'hFFFF and clear on reset.
  - A misaligned taken target counts as taken.
- BRANCH_STATS_EN undefined: both ports tied to 0 and no counter flops are built.

## Test plan
- BrValid=OpReady=Taken=1, Target=0x0040_0010, FetchReady=1 → BrAck in N; Redirect=1 with RedirectPC=0x0040_0010 and Flush=1 in N+1; Redirect=0 in N+2.
- Same stimulus with FetchReady=0 for 3 cycles → Redirect and Stall held 3 cycles with PC stable; Flush only in the cycle FetchReady=1.
- OpReady=0 for 2 cycles, then 1, Taken=0 → Stall 2 cycles; BrAck in cycle 3; no Redirect; NotTakenCount=1 (stats build).
- JALR, IsLink=1, LinkReg=5, Ret=0x1000_0008, Taken=1 → LinkWe=1 for one cycle with LinkAddr=5 and LinkData=0x1000_0008, concurrent with Redirect.
- Taken=1, Target=0x0000_0102 → AddrErr pulse in N+1; Redirect never asserted; state IDLE.
- nRst low during REDIRECT → all outputs 0 immediately; after release, no redirect and no link write occur.
